// File: rtl/wallace_product_accumulator.sv
// wallace_product_accumulator: registered CPA merge of sum/carry rows into a saturating run accumulator with valid/ready readout.
// Optional macro APPROX_ACC_EN: OR-combines the low APPROX_LSBS accumulator bits instead of adding them.
module wallace_product_accumulator #(
  parameter int LEN = 4,
  parameter int ACC_W = 24,
  parameter int APPROX_LSBS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      sum_in,
  input  logic [15:0]      carry_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf_out,
  output logic             out_valid,
  input  logic             out_ready
);
  typedef enum logic [1:0] {ACCUM, DONE, CLEAR} state_t;
  localparam logic [7:0] LEN_C = 8'(LEN);
  state_t           state;
  logic [16:0]      prod_q;
  logic             p_vld;
  logic [7:0]       cnt;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [ACC_W-1:0] acc_nxt;
  logic             sat;
  logic             accept;
  logic [ACC_W:0]   prod_x;
  if (LEN < 1 || LEN > 255 || ACC_W < 17 || APPROX_LSBS < 0 || APPROX_LSBS > 16) begin : g_bad
    $error("wallace_product_accumulator: parameter out of range");
  end
  assign in_ready  = state == ACCUM && cnt < LEN_C;
  assign out_valid = state == DONE;
  assign acc_out   = acc;
  assign ovf_out   = ovf;
  assign accept    = in_valid & in_ready;
  assign prod_x    = (ACC_W+1)'(prod_q);
`ifdef APPROX_ACC_EN
  localparam int L = APPROX_LSBS;
  localparam logic [ACC_W:0] MASK = (ACC_W+1)'((64'd1 << L) - 64'd1);
  logic [ACC_W:0] hi;
  // low field is carry-free; saturation only looks at the exact upper part
  always_comb begin
    hi      = ({1'b0, acc} >> L) + (prod_x >> L);
    sat     = |(hi >> (ACC_W - L));
    acc_nxt = sat ? '1 : ACC_W'((hi << L) | (({1'b0, acc} | prod_x) & MASK));
  end
`else
  logic [ACC_W:0] sum;
  always_comb begin
    sum     = {1'b0, acc} + prod_x;
    sat     = sum[ACC_W];
    acc_nxt = sat ? '1 : sum[ACC_W-1:0];
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ACCUM;
      prod_q <= '0;
      p_vld  <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      ovf    <= 1'b0;
    end else begin
      p_vld <= accept;
      if (accept) begin
        prod_q <= 17'(sum_in) + 17'(carry_in);
        cnt    <= cnt + 8'd1;
      end
      if (state == CLEAR) begin
        acc <= '0;
        ovf <= 1'b0;
        cnt <= '0;
      end else if (p_vld) begin
        acc <= acc_nxt;
        ovf <= ovf | sat;
      end
      // DONE only once the last product has left the CPA register
      state <= state == ACCUM ? ((cnt == LEN_C && !p_vld) ? DONE : ACCUM)
             : state == DONE  ? (out_ready ? CLEAR : DONE)
             : ACCUM;
    end
  end
endmodule
